// File: rtl/safebox_pkg.sv
// Shared definitions for the safe box: FSM state encoding and keypad key codes.
// Used by the lock controller and by the scanner/display blocks.
package safebox_pkg;

    typedef enum logic [2:0] {
        ST_LOCKED   = 3'd0,
        ST_CHECK    = 3'd1,
        ST_UNLOCKED = 3'd2,
        ST_SET_NEW  = 3'd3,
        ST_LOCKOUT  = 3'd4
    } state_e;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;
    localparam logic [3:0] KEY_SET   = 4'hC;
    localparam logic [3:0] KEY_LOCK  = 4'hF;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter. expire is registered and is high in the cycle the count equals 1.
module lock_timer #(
    parameter int unsigned WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expire
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             expire_q, expire_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
        // Look ahead so expire lines up with the cycle the count holds 1.
        expire_d = (count_d == WIDTH'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            expire_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            expire_q <= expire_d;
        end
    end

    assign expire = expire_q;

endmodule

// File: rtl/safe_lock_ctrl.sv
// Safe box lock controller: assembles 4-digit keypad entries, checks them against the
// stored password, and handles lockout, auto-relock and password change.
module safe_lock_ctrl
    import safebox_pkg::*;
#(
    parameter logic [15:0] DEFAULT_PW     = 16'h358B,
    parameter int unsigned MAX_FAIL       = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1000,
    parameter int unsigned UNLOCK_TIMEOUT = 5000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             key_valid,
    input  logic [3:0]                       key_code,
    output logic                             unlocked,
    output logic                             alarm,
    output logic                             pw_ok,
    output logic                             pw_err,
    output logic [2:0]                       entry_cnt,
    output logic [15:0]                      entry_disp,
    output logic [$clog2(MAX_FAIL+1)-1:0]    fail_cnt
);

    localparam int unsigned FAIL_W  = $clog2(MAX_FAIL + 1);
    localparam int unsigned TMR_MAX = (LOCKOUT_CYCLES > UNLOCK_TIMEOUT) ? LOCKOUT_CYCLES : UNLOCK_TIMEOUT;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    state_e            state_q, state_d;
    logic [15:0]       buf_q, buf_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [15:0]       pw_q, pw_d;
    logic [FAIL_W-1:0] fail_q, fail_d;
    logic              pw_ok_q, pw_ok_d;
    logic              pw_err_q, pw_err_d;
    logic              unlocked_q, unlocked_d;
    logic              alarm_q, alarm_d;

    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_en;
    logic              tmr_expire;
    logic [FAIL_W-1:0] fail_inc;

    assign fail_inc = fail_q + FAIL_W'(1);
    assign tmr_en   = (state_q == ST_UNLOCKED) || (state_q == ST_SET_NEW) || (state_q == ST_LOCKOUT);

    lock_timer #(
        .WIDTH    (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expire   (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        pw_d     = pw_q;
        fail_d   = fail_q;
        pw_ok_d  = 1'b0;
        pw_err_d = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = TMR_W'(UNLOCK_TIMEOUT);

        unique case (state_q)
            ST_LOCKED: begin
                if (key_valid) begin
                    if (is_digit(key_code)) begin
                        if (cnt_q < 3'd4) begin
                            buf_d = {buf_q[11:0], key_code};
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        buf_d = '0;
                        cnt_d = '0;
                    end else if (key_code == KEY_ENTER) begin
                        if (cnt_q == 3'd4) begin
                            state_d = ST_CHECK;
                        end else begin
                            pw_err_d = 1'b1;
                            buf_d    = '0;
                            cnt_d    = '0;
                        end
                    end
                end
            end

            ST_CHECK: begin
                buf_d = '0;
                cnt_d = '0;
                if (buf_q == pw_q) begin
                    state_d  = ST_UNLOCKED;
                    pw_ok_d  = 1'b1;
                    fail_d   = '0;
                    tmr_load = 1'b1;
                end else begin
                    pw_err_d = 1'b1;
                    fail_d   = fail_inc;
                    if (fail_inc == FAIL_W'(MAX_FAIL)) begin
                        state_d  = ST_LOCKOUT;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(LOCKOUT_CYCLES);
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
            end

            ST_UNLOCKED: begin
                // Expiry takes priority over any key arriving in the same cycle.
                if (tmr_expire) begin
                    state_d = ST_LOCKED;
                    buf_d   = '0;
                    cnt_d   = '0;
                end else if (key_valid) begin
                    tmr_load = 1'b1;
                    if (key_code == KEY_LOCK) begin
                        state_d = ST_LOCKED;
                        buf_d   = '0;
                        cnt_d   = '0;
                    end else if (key_code == KEY_SET) begin
                        state_d = ST_SET_NEW;
                        buf_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end

            ST_SET_NEW: begin
                if (tmr_expire) begin
                    state_d = ST_LOCKED;
                    buf_d   = '0;
                    cnt_d   = '0;
                end else if (key_valid) begin
                    tmr_load = 1'b1;
                    if (is_digit(key_code)) begin
                        if (cnt_q < 3'd4) begin
                            buf_d = {buf_q[11:0], key_code};
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        buf_d = '0;
                        cnt_d = '0;
                    end else if (key_code == KEY_ENTER) begin
                        buf_d = '0;
                        cnt_d = '0;
                        if (cnt_q == 3'd4) begin
                            pw_d    = buf_q;
                            pw_ok_d = 1'b1;
                            state_d = ST_UNLOCKED;
                        end else begin
                            pw_err_d = 1'b1;
                        end
                    end else if (key_code == KEY_LOCK) begin
                        state_d = ST_UNLOCKED;
                        buf_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end

            ST_LOCKOUT: begin
                if (tmr_expire) begin
                    state_d = ST_LOCKED;
                    fail_d  = '0;
                end
            end

            default: begin
                state_d = ST_LOCKED;
                buf_d   = '0;
                cnt_d   = '0;
            end
        endcase

        unlocked_d = (state_d == ST_UNLOCKED) || (state_d == ST_SET_NEW);
        alarm_d    = (state_d == ST_LOCKOUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LOCKED;
            buf_q      <= '0;
            cnt_q      <= '0;
            pw_q       <= DEFAULT_PW;
            fail_q     <= '0;
            pw_ok_q    <= 1'b0;
            pw_err_q   <= 1'b0;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            pw_q       <= pw_d;
            fail_q     <= fail_d;
            pw_ok_q    <= pw_ok_d;
            pw_err_q   <= pw_err_d;
            unlocked_q <= unlocked_d;
            alarm_q    <= alarm_d;
        end
    end

    assign unlocked   = unlocked_q;
    assign alarm      = alarm_q;
    assign pw_ok      = pw_ok_q;
    assign pw_err     = pw_err_q;
    assign entry_cnt  = cnt_q;
    assign entry_disp = buf_q;
    assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Directed self-checking bench for safe_lock_ctrl. Keys are driven on the falling edge
// and outputs are sampled on the falling edge, half a cycle away from the active edge.
module tb_safe_lock_ctrl;
    import safebox_pkg::*;

    // 0xB is the CLEAR key, so the reset password uses only enterable digits.
    localparam logic [15:0] TB_PW = 16'h3589;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        unlocked;
    logic        alarm;
    logic        pw_ok;
    logic        pw_err;
    logic [2:0]  entry_cnt;
    logic [15:0] entry_disp;
    logic [1:0]  fail_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    safe_lock_ctrl #(
        .DEFAULT_PW     (TB_PW),
        .MAX_FAIL       (3),
        .LOCKOUT_CYCLES (1000),
        .UNLOCK_TIMEOUT (5000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .unlocked   (unlocked),
        .alarm      (alarm),
        .pw_ok      (pw_ok),
        .pw_err     (pw_err),
        .entry_cnt  (entry_cnt),
        .entry_disp (entry_disp),
        .fail_cnt   (fail_cnt)
    );

    // Called at a falling edge; returns at the next falling edge after the key was sampled.
    task automatic press(input logic [3:0] k);
        key_code  = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    // Four digits then ENTER; returns in the CHECK cycle.
    task automatic enter_pw(input logic [15:0] pw);
        press(pw[15:12]);
        press(pw[11:8]);
        press(pw[7:4]);
        press(pw[3:0]);
        press(KEY_ENTER);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        key_valid = 1'b0;
        key_code = 4'h0;
        repeat (3) @(negedge clk);
        if (unlocked !== 1'b0) begin $display("FAIL reset_unlocked got %0b want 0", unlocked); errors++; end checks++;
        if (alarm !== 1'b0) begin $display("FAIL reset_alarm got %0b want 0", alarm); errors++; end checks++;
        if (pw_ok !== 1'b0 || pw_err !== 1'b0) begin $display("FAIL reset_pulses got ok=%0b err=%0b want 0 0", pw_ok, pw_err); errors++; end checks++;
        if (entry_cnt !== 3'd0 || entry_disp !== 16'h0) begin $display("FAIL reset_entry got %0d/%h want 0/0000", entry_cnt, entry_disp); errors++; end checks++;
        if (fail_cnt !== 2'd0) begin $display("FAIL reset_fail got %0d want 0", fail_cnt); errors++; end checks++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unlock();
        enter_pw(16'h1111);
        @(negedge clk);
        if (pw_err !== 1'b1 || fail_cnt !== 2'd1) begin $display("FAIL unlock_wrong got err=%0b fail=%0d want 1 1", pw_err, fail_cnt); errors++; end checks++;
        enter_pw(TB_PW);
        if (pw_ok !== 1'b0 || unlocked !== 1'b0) begin $display("FAIL unlock_check_cycle got ok=%0b unl=%0b want 0 0", pw_ok, unlocked); errors++; end checks++;
        @(negedge clk);
        if (pw_ok !== 1'b1 || pw_err !== 1'b0) begin $display("FAIL unlock_pw_ok got ok=%0b err=%0b want 1 0", pw_ok, pw_err); errors++; end checks++;
        if (unlocked !== 1'b1) begin $display("FAIL unlock_unlocked got %0b want 1", unlocked); errors++; end checks++;
        if (fail_cnt !== 2'd0 || entry_cnt !== 3'd0) begin $display("FAIL unlock_clear got fail=%0d cnt=%0d want 0 0", fail_cnt, entry_cnt); errors++; end checks++;
        @(negedge clk);
        if (pw_ok !== 1'b0) begin $display("FAIL unlock_pulse_width got %0b want 0", pw_ok); errors++; end checks++;
        press(KEY_LOCK);
        if (unlocked !== 1'b0) begin $display("FAIL unlock_lock_key got %0b want 0", unlocked); errors++; end checks++;
    endtask

    task automatic test_entry();
        press(4'h1);
        press(4'h2);
        press(KEY_ENTER);
        if (pw_err !== 1'b1 || entry_cnt !== 3'd0) begin $display("FAIL entry_short got err=%0b cnt=%0d want 1 0", pw_err, entry_cnt); errors++; end checks++;
        @(negedge clk);
        if (pw_err !== 1'b0) begin $display("FAIL entry_short_pulse got %0b want 0", pw_err); errors++; end checks++;
        press(4'h3); press(4'h5); press(4'h8); press(4'h9); press(4'h7);
        if (entry_cnt !== 3'd4 || entry_disp !== 16'h3589) begin $display("FAIL entry_fifth_dropped got %0d/%h want 4/3589", entry_cnt, entry_disp); errors++; end checks++;
        press(KEY_CLEAR);
        if (entry_cnt !== 3'd0 || entry_disp !== 16'h0) begin $display("FAIL entry_clear got %0d/%h want 0/0000", entry_cnt, entry_disp); errors++; end checks++;
        press(4'h1); press(4'hD); press(KEY_SET); press(KEY_LOCK);
        if (entry_cnt !== 3'd1 || entry_disp !== 16'h0001 || unlocked !== 1'b0) begin $display("FAIL entry_unused_keys got %0d/%h unl=%0b want 1/0001 0", entry_cnt, entry_disp, unlocked); errors++; end checks++;
        press(KEY_CLEAR);
    endtask

    task automatic test_lockout();
        for (int i = 0; i < 3; i++) begin
            logic [1:0] exp_fail;
            logic       exp_alarm;
            exp_fail  = 2'(i + 1);
            exp_alarm = (i == 2);
            enter_pw(16'h1234);
            @(negedge clk);
            if (pw_err !== 1'b1 || fail_cnt !== exp_fail || alarm !== exp_alarm) begin
                $display("FAIL lockout_attempt%0d got err=%0b fail=%0d alarm=%0b want 1 %0d %0b", i, pw_err, fail_cnt, alarm, exp_fail, exp_alarm);
                errors++;
            end
            checks++;
        end
        // Now in lockout cycle 1; correct password must be ignored.
        enter_pw(TB_PW);
        if (entry_cnt !== 3'd0 || alarm !== 1'b1) begin $display("FAIL lockout_keys_ignored got cnt=%0d alarm=%0b want 0 1", entry_cnt, alarm); errors++; end checks++;
        @(negedge clk);
        if (unlocked !== 1'b0 || pw_ok !== 1'b0) begin $display("FAIL lockout_no_unlock got unl=%0b ok=%0b want 0 0", unlocked, pw_ok); errors++; end checks++;
        repeat (993) @(negedge clk);
        if (alarm !== 1'b1) begin $display("FAIL lockout_last_cycle got %0b want 1", alarm); errors++; end checks++;
        @(negedge clk);
        if (alarm !== 1'b0 || fail_cnt !== 2'd0) begin $display("FAIL lockout_release got alarm=%0b fail=%0d want 0 0", alarm, fail_cnt); errors++; end checks++;
        enter_pw(TB_PW);
        @(negedge clk);
        if (unlocked !== 1'b1) begin $display("FAIL lockout_then_unlock got %0b want 1", unlocked); errors++; end checks++;
        press(KEY_LOCK);
    endtask

    task automatic test_change_pw();
        enter_pw(TB_PW);
        @(negedge clk);
        press(KEY_SET);
        if (unlocked !== 1'b1) begin $display("FAIL chg_set_new_unlocked got %0b want 1", unlocked); errors++; end checks++;
        press(4'h9); press(4'h9); press(KEY_ENTER);
        if (pw_err !== 1'b1 || unlocked !== 1'b1 || entry_cnt !== 3'd0) begin $display("FAIL chg_short got err=%0b unl=%0b cnt=%0d want 1 1 0", pw_err, unlocked, entry_cnt); errors++; end checks++;
        press(4'h9); press(4'h9); press(4'h0); press(4'h1);
        if (entry_cnt !== 3'd4 || entry_disp !== 16'h9901) begin $display("FAIL chg_buffer got %0d/%h want 4/9901", entry_cnt, entry_disp); errors++; end checks++;
        press(KEY_ENTER);
        if (pw_ok !== 1'b1 || unlocked !== 1'b1 || entry_cnt !== 3'd0) begin $display("FAIL chg_store got ok=%0b unl=%0b cnt=%0d want 1 1 0", pw_ok, unlocked, entry_cnt); errors++; end checks++;
        press(KEY_LOCK);
        enter_pw(16'h9901);
        @(negedge clk);
        if (unlocked !== 1'b1 || pw_ok !== 1'b1) begin $display("FAIL chg_new_pw got unl=%0b ok=%0b want 1 1", unlocked, pw_ok); errors++; end checks++;
        // Aborting SET_NEW with LOCK keeps the stored password.
        press(KEY_SET); press(4'h1); press(4'h1); press(KEY_LOCK);
        if (unlocked !== 1'b1 || entry_cnt !== 3'd0) begin $display("FAIL chg_abort got unl=%0b cnt=%0d want 1 0", unlocked, entry_cnt); errors++; end checks++;
        press(KEY_LOCK);
        enter_pw(TB_PW);
        @(negedge clk);
        if (unlocked !== 1'b0 || pw_err !== 1'b1) begin $display("FAIL chg_old_pw_rejected got unl=%0b err=%0b want 0 1", unlocked, pw_err); errors++; end checks++;
        enter_pw(16'h9901);
        @(negedge clk);
        if (unlocked !== 1'b1) begin $display("FAIL chg_abort_kept got %0b want 1", unlocked); errors++; end checks++;
        press(KEY_LOCK);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        enter_pw(TB_PW);
        @(negedge clk);
        if (unlocked !== 1'b1 || pw_ok !== 1'b1) begin $display("FAIL chg_reset_reverts got unl=%0b ok=%0b want 1 1", unlocked, pw_ok); errors++; end checks++;
        press(KEY_LOCK);
    endtask

    task automatic test_timeout();
        enter_pw(TB_PW);
        @(negedge clk);
        repeat (4999) @(negedge clk);
        if (unlocked !== 1'b1) begin $display("FAIL timeout_last_cycle got %0b want 1", unlocked); errors++; end checks++;
        @(negedge clk);
        if (unlocked !== 1'b0) begin $display("FAIL timeout_relock got %0b want 0", unlocked); errors++; end checks++;
        enter_pw(TB_PW);
        @(negedge clk);
        repeat (4998) @(negedge clk);
        press(4'hD);
        @(negedge clk);
        if (unlocked !== 1'b1) begin $display("FAIL timeout_reload got %0b want 1", unlocked); errors++; end checks++;
        // Key in the expiry cycle is dropped: SET would otherwise keep it unlocked.
        repeat (4998) @(negedge clk);
        press(KEY_SET);
        if (unlocked !== 1'b0 || entry_cnt !== 3'd0) begin $display("FAIL timeout_wins got unl=%0b cnt=%0d want 0 0", unlocked, entry_cnt); errors++; end checks++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            enter_pw(16'h4444);
            @(negedge clk);
        end
        if (alarm !== 1'b1) begin $display("FAIL rstmid_in_lockout got %0b want 1", alarm); errors++; end checks++;
        rst = 1'b1;
        #1;
        if (alarm !== 1'b0 || fail_cnt !== 2'd0 || pw_err !== 1'b0) begin $display("FAIL rstmid_lockout got alarm=%0b fail=%0d err=%0b want 0 0 0", alarm, fail_cnt, pw_err); errors++; end checks++;
        @(negedge clk);
        rst = 1'b0;
        enter_pw(TB_PW);
        @(negedge clk);
        press(KEY_SET);
        press(4'h1);
        press(4'h2);
        rst = 1'b1;
        #1;
        if (unlocked !== 1'b0 || entry_cnt !== 3'd0 || entry_disp !== 16'h0 || pw_ok !== 1'b0) begin
            $display("FAIL rstmid_set_new got unl=%0b cnt=%0d disp=%h ok=%0b want 0 0 0000 0", unlocked, entry_cnt, entry_disp, pw_ok);
            errors++;
        end
        checks++;
        @(negedge clk);
        rst = 1'b0;
        enter_pw(TB_PW);
        @(negedge clk);
        if (unlocked !== 1'b1) begin $display("FAIL rstmid_recover got %0b want 1", unlocked); errors++; end checks++;
        press(KEY_LOCK);
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_entry();
        test_lockout();
        test_change_pw();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
